// File: rtl/ws2812b_pixel.sv
// ws2812b_pixel -- one WS2812B addressable RGB LED, clocked at 100 MHz.
//
// Purpose:
//   Decodes the single-wire NRZ pulse stream on din. The first 3*PWM_BITS bits
//   (G, R, B, each MSB first) are captured. Every later bit is forwarded on
//   dout with its pulse width intact, so pixels can be daisy-chained. A low
//   run of RESET_CYCLES clocks latches a complete frame into the colour
//   registers. The colour registers drive three registered PWM outputs.
//
// Ports:
//   clk_100MHz  in   system clock; all logic runs on its rising edge
//   rst         in   synchronous, active-high reset
//   din         in   serial NRZ data in
//   dout        out  serial data out to the next pixel
//   rled        out  red PWM output
//   gled        out  green PWM output
//   bled        out  blue PWM output
//
// Parameters:
//   BIT_THRESH    high-pulse length (clocks) at or above which a bit is a 1
//   RESET_CYCLES  consecutive low clocks that form the reset/latch code
//   PWM_BITS      width of each colour byte and of the PWM counter
//
// Build option:
//   WS2812B_SYNC_EN  when defined, din passes through a 2-flop synchronizer
//                    before the sampling register. This adds 2 clocks of
//                    latency to decode, dout and the latch.
module ws2812b_pixel #(
  parameter int BIT_THRESH   = 62,
  parameter int RESET_CYCLES = 5000,
  parameter int PWM_BITS     = 8
) (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rled,
  output logic gled,
  output logic bled
);

  localparam int FRAME_BITS = 3 * PWM_BITS;
  localparam int BC_W       = $clog2(FRAME_BITS + 1);
  localparam int LO_W       = $clog2(RESET_CYCLES + 1);

  localparam logic [BC_W-1:0] BC_FULL  = BC_W'(FRAME_BITS);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(FRAME_BITS - 1);
  localparam logic [LO_W-1:0] LO_MAX   = LO_W'(RESET_CYCLES);
  localparam logic [LO_W-1:0] LO_LAST  = LO_W'(RESET_CYCLES - 1);
  localparam logic [7:0]      HI_THR   = 8'(BIT_THRESH);

  typedef enum logic {
    ST_CAPTURE = 1'b0,   // shifting bits into this pixel
    ST_FORWARD = 1'b1    // frame full, passing bits downstream
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic din_pre;

`ifdef WS2812B_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign din_pre = sync_q[1];
`else
  assign din_pre = din;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                          din_s_q;
  logic                          din_prev_q;
  logic [7:0]                    hi_cnt_q,  hi_cnt_d;
  logic [LO_W-1:0]               lo_cnt_q,  lo_cnt_d;
  logic [FRAME_BITS-1:0]         shift_q,   shift_d;
  logic [BC_W-1:0]               bit_cnt_q, bit_cnt_d;
  state_t                        state_q,   state_d;
  // colour_q[2] = G, colour_q[1] = R, colour_q[0] = B (same layout as shift_q)
  logic [2:0][PWM_BITS-1:0]      colour_q,  colour_d;
  logic                          dout_q,    dout_d;
  logic [PWM_BITS-1:0]           pwm_cnt_q;
  logic [2:0]                    led_q,     led_d;

  logic rise;
  logic fall;
  logic bit_val;
  logic latch;

  assign rise    = din_s_q & ~din_prev_q;
  assign fall    = ~din_s_q & din_prev_q;
  // hi_cnt_q holds the full pulse length on the clock the fall is seen.
  assign bit_val = (hi_cnt_q >= HI_THR);
  // Fires only on the transition into saturation, so once per low period.
  assign latch   = ~din_s_q & (lo_cnt_q == LO_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    state_d   = state_q;
    colour_d  = colour_q;
    dout_d    = 1'b0;

    // High-pulse width, saturating at 255.
    if (rise) begin
      hi_cnt_d = 8'd1;
    end else if (din_s_q && (hi_cnt_q != 8'hFF)) begin
      hi_cnt_d = hi_cnt_q + 8'd1;
    end

    // Low-run length, saturating at RESET_CYCLES.
    if (din_s_q) begin
      lo_cnt_d = '0;
    end else if (lo_cnt_q != LO_MAX) begin
      lo_cnt_d = lo_cnt_q + LO_W'(1);
    end

    case (state_q)
      ST_CAPTURE: begin
        if (fall) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], bit_val};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == BC_LAST) begin
            state_d = ST_FORWARD;
          end
        end
      end
      ST_FORWARD: begin
        dout_d = din_s_q;
      end
      default: begin
        state_d = ST_CAPTURE;
      end
    endcase

    // The latch code ends the frame; incomplete frames are dropped.
    if (latch) begin
      if (bit_cnt_q == BC_FULL) begin
        colour_d = shift_q;
      end
      bit_cnt_d = '0;
      shift_d   = '0;
      state_d   = ST_CAPTURE;
    end
  end

  // PWM comparators, one per colour channel.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pwm
      assign led_d[gi] = (pwm_cnt_q < colour_q[gi]);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      din_s_q    <= 1'b0;
      din_prev_q <= 1'b0;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      state_q    <= ST_CAPTURE;
      colour_q   <= '0;
      dout_q     <= 1'b0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
    end else begin
      din_s_q    <= din_pre;
      din_prev_q <= din_s_q;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      state_q    <= state_d;
      colour_q   <= colour_d;
      dout_q     <= dout_d;
      pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
      led_q      <= led_d;
    end
  end

  assign dout = dout_q;
  assign gled = led_q[2];
  assign rled = led_q[1];
  assign bled = led_q[0];

endmodule

// File: tb/tb_ws2812b_pixel.sv
// Bench for ws2812b_pixel: two pixels daisy-chained (dut1.dout -> dut2.din).
// Stimulus pushes expected dout pulses (rise cycle, width) and expected colour
// duty cycles into queues; independent monitors pop and compare them.
module tb_ws2812b_pixel;

`ifdef WS2812B_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout1, rled1, gled1, bled1;
  logic dout2, rled2, gled2, bled2;

  always #5 clk = ~clk;

  ws2812b_pixel dut1 (
    .clk_100MHz(clk), .rst(rst), .din(din),
    .dout(dout1), .rled(rled1), .gled(gled1), .bled(bled1)
  );

  ws2812b_pixel dut2 (
    .clk_100MHz(clk), .rst(rst), .din(dout1),
    .dout(dout2), .rled(rled2), .gled(gled2), .bled(bled2)
  );

  typedef struct {
    int rise;
    int width;
  } pulse_t;

  typedef struct {
    int    px;
    int    g;
    int    r;
    int    b;
    string name;
  } meas_t;

  pulse_t q1[$];
  pulse_t q2[$];
  meas_t  mq[$];

  int  tests  = 0;
  int  fails  = 0;
  int  cyc    = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- dout pulse monitor ----------------
  task automatic watch_dout(input int idx);
    logic   prev;
    logic   cur;
    int     rise_c;
    int     have;
    pulse_t e;
    prev   = 1'b0;
    rise_c = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = (idx == 1) ? dout1 : dout2;
      if (cur && !prev) rise_c = cyc;
      if (!cur && prev) begin
        have = (idx == 1) ? q1.size() : q2.size();
        if (have == 0) begin
          tests++;
          fails++;
          $display("FAIL dout%0d_unexpected: pulse at cycle %0d width %0d, expected no pulse",
                   idx, rise_c, cyc - rise_c);
        end else begin
          if (idx == 1) e = q1.pop_front();
          else          e = q2.pop_front();
          check($sformatf("dout%0d_rise", idx), rise_c, e.rise);
          check($sformatf("dout%0d_width", idx), cyc - rise_c, e.width);
          $display("[TB] dout%0d pulse rise=%0d width=%0d", idx, rise_c, cyc - rise_c);
        end
      end
      prev = cur;
    end
  endtask

  initial watch_dout(1);
  initial watch_dout(2);

  // ---------------- PWM duty monitor ----------------
  initial begin : duty_mon
    meas_t m;
    int    cg;
    int    cr;
    int    cb;
    forever begin
      @(negedge clk);
      if (mq.size() > 0) begin
        cg = 0; cr = 0; cb = 0;
        for (int i = 0; i < 256; i++) begin
          if (mq[0].px == 1) begin
            cg += int'(gled1); cr += int'(rled1); cb += int'(bled1);
          end else begin
            cg += int'(gled2); cr += int'(rled2); cb += int'(bled2);
          end
          @(negedge clk);
        end
        m = mq.pop_front();
        check({m.name, "_g"}, cg, m.g);
        check({m.name, "_r"}, cr, m.r);
        check({m.name, "_b"}, cb, m.b);
        $display("[TB] %s px%0d duty G=%0d R=%0d B=%0d", m.name, m.px, cg, cr, cb);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send_bit(input int hi, input int lo, input bit f1, input bit f2);
    pulse_t p;
    din    = 1'b1;
    p.width = hi;
    if (f1) begin p.rise = cyc + LAT;     q1.push_back(p); end
    if (f2) begin p.rise = cyc + 2 * LAT; q2.push_back(p); end
    repeat (hi) @(posedge clk);
    #1;
    din = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic hold_low(input int n);
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] val, input int nbits,
                            input int f1_from, input int f2_from,
                            input int gap_idx, input int gap_lo);
    int hi;
    int lo;
    for (int i = 0; i < nbits; i++) begin
      hi = val[nbits-1-i] ? 90 : 35;
      lo = (i == gap_idx) ? gap_lo : 125 - hi;
      send_bit(hi, lo, i >= f1_from, i >= f2_from);
    end
  endtask

  task automatic measure(input int px, input int g, input int r, input int b,
                         input string name);
    meas_t m;
    int    guard;
    m.px = px; m.g = g; m.r = r; m.b = b; m.name = name;
    mq.push_back(m);
    guard = 0;
    while (mq.size() != 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: duty monitor idle after %0d cycles, expected completion", name, guard);
      mq.delete();
    end
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [23:0] thr_bits;
    int          hi;

    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout1", int'(dout1), 0);
    check("rst_dout2", int'(dout2), 0);
    check("rst_rled1", int'(rled1), 0);
    check("rst_gled1", int'(gled1), 0);
    check("rst_bled1", int'(bled1), 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    measure(1, 0, 0, 0, "reset_px1");
    measure(2, 0, 0, 0, "reset_px2");

    // Single pixel frame, nothing forwarded.
    send_frame(64'h40C07F, 24, 99, 99, -1, 0);
    hold_low(5100);
    measure(1, 8'h40, 8'hC0, 8'h7F, "single");

    // Threshold: 61 clocks -> 0, 62 clocks -> 1.
    thr_bits = 24'h550001;
    for (int i = 0; i < 24; i++) begin
      hi = thr_bits[23-i] ? 62 : 61;
      send_bit(hi, 125 - hi, 1'b0, 1'b0);
    end
    hold_low(5100);
    measure(1, 8'h55, 8'h00, 8'h01, "threshold");

    // Partial frame is discarded, then a full frame lands.
    send_frame(64'h3FF, 10, 99, 99, -1, 0);
    hold_low(5100);
    measure(1, 8'h55, 8'h00, 8'h01, "partial");
    send_frame(64'hFF00FF, 24, 99, 99, -1, 0);
    hold_low(5100);
    measure(1, 8'hFF, 8'h00, 8'hFF, "ff00ff");

    // 4999-clock gap mid-frame must not latch; exactly 5000 must latch.
    // The extra pulse after the latch starts a new (discarded) frame and
    // must not appear on dout.
    send_frame(64'h12A, 12, 99, 99, 11, 4999);
    send_frame(64'h5C3, 12, 99, 99, 11, 5000);
    send_bit(35, 90, 1'b0, 1'b0);
    hold_low(5100);
    measure(1, 8'h12, 8'hA5, 8'hC3, "short_gap");

    // Two-pixel chain: 48 colour bits plus one trailing 0 bit.
    send_frame({15'd0, 48'h40C07F007FFF, 1'b0}, 49, 24, 48, -1, 0);
    hold_low(5100);
    measure(1, 8'h40, 8'hC0, 8'h7F, "chain_px1");
    measure(2, 8'h00, 8'h7F, 8'hFF, "chain_px2");

    hold_low(20);
    check("dout1_pending", q1.size(), 0);
    check("dout2_pending", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
